// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: launches the shared multiply/divide units, waits out their
// fixed latency, and writes results into HI/LO or raises a divide-by-zero pulse.
module hilo_muldiv_ctrl #(
  parameter int unsigned MULT_LATENCY = 33,
  parameter int unsigned DIV_LATENCY  = 34,
  parameter int unsigned CNT_W        = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  output logic        div_start,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0_exc
);

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;

  // WAIT ends when the counter reaches LAT-2, giving LAT-1 WAIT cycles
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LATENCY - 2);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_LATENCY - 2);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, WB} state_t;

  state_t           state;
  logic             op_div;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;
  logic             accept;
  logic             abort;

  assign accept = op_valid && op_ready;
  assign last   = op_div ? DIV_LAST : MULT_LAST;
  assign abort  = op_div && div_zero;

  // Controller state, counter and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op_div     <= 1'b0;
      count      <= '0;
      op_ready   <= 1'b1;
      busy       <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      div0_exc   <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      done       <= 1'b0;
      div0_exc   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            unit_a <= op_a;
            unit_b <= op_b;
            case (op_code)
              OP_MULT: begin
                op_div     <= 1'b0;
                mult_start <= 1'b1;
                state      <= LAUNCH;
                busy       <= 1'b1;
                op_ready   <= 1'b0;
              end
              OP_DIV: begin
                if (op_b == '0) begin
                  div0_exc <= 1'b1;
                end else begin
                  op_div    <= 1'b1;
                  div_start <= 1'b1;
                  state     <= LAUNCH;
                  busy      <= 1'b1;
                  op_ready  <= 1'b0;
                end
              end
              OP_MTHI: begin
                hi   <= op_a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= op_a;
                done <= 1'b1;
              end
              default: done <= 1'b1;
            endcase
          end
        end
        LAUNCH: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (abort) begin
            div0_exc <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
            op_ready <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
            if (count == last) state <= WB;
          end
        end
        WB: begin
          if (abort) begin
            div0_exc <= 1'b1;
          end else begin
            hi   <= op_div ? div_hi : mult_hi;
            lo   <= op_div ? div_lo : mult_lo;
            done <= 1'b1;
          end
          state    <= IDLE;
          busy     <= 1'b0;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with stub multiply/divide units whose
// results are valid only in the exact latency cycle.
module tb_hilo_muldiv_ctrl;

  localparam int unsigned MLAT = 33;
  localparam int unsigned DLAT = 34;

  localparam logic [2:0] MULT = 3'b000;
  localparam logic [2:0] DIV  = 3'b001;
  localparam logic [2:0] MTHI = 3'b010;
  localparam logic [2:0] MTLO = 3'b011;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        op_ready;
  logic [31:0] unit_a, unit_b;
  logic        mult_start, div_start;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        div_zero;
  logic [31:0] hi, lo;
  logic        busy, done, div0_exc;

  int checks = 0;
  int errors = 0;
  logic force_dz = 1'b0;

  hilo_muldiv_ctrl #(.MULT_LATENCY(MLAT), .DIV_LATENCY(DLAT), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .unit_a(unit_a),
    .unit_b(unit_b), .mult_start(mult_start), .div_start(div_start),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .div_zero(div_zero), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div0_exc(div0_exc)
  );

  always #5 clock = ~clock;

  // Stub units: operands captured at the start pulse, result valid only LAT cycles later
  int mcnt, dcnt;
  logic signed [31:0] ma, mb, da, db;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;

  always_ff @(posedge clock) begin
    if (reset) begin
      mcnt <= 0;
      dcnt <= 0;
    end else begin
      if (mult_start) begin
        mcnt <= 1; ma <= unit_a; mb <= unit_b;
      end else if (mcnt != 0) mcnt <= mcnt + 1;
      if (div_start) begin
        dcnt <= 1; da <= unit_a; db <= unit_b;
      end else if (dcnt != 0) dcnt <= dcnt + 1;
    end
  end

  assign prod     = ma * mb;
  assign quo      = (db == 0) ? 32'sd0 : da / db;
  assign rem      = (db == 0) ? 32'sd0 : da % db;
  assign mult_hi  = (mcnt == MLAT) ? prod[63:32] : 32'hBAD0BAD0;
  assign mult_lo  = (mcnt == MLAT) ? prod[31:0]  : 32'hBAD1BAD1;
  assign div_hi   = (dcnt == DLAT) ? rem : 32'hBAD2BAD2;
  assign div_lo   = (dcnt == DLAT) ? quo : 32'hBAD3BAD3;
  assign div_zero = force_dz;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {busy, mult_start, div_start, done, div0_exc}
  function automatic logic [4:0] status();
    return {busy, mult_start, div_start, done, div0_exc};
  endfunction

  // Accept one MULT/DIV in the current cycle and follow it to writeback
  task automatic run_op(input string nm, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned lat,
                        input logic [31:0] eh, input logic [31:0] el);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    step();
    op_valid = 1'b0;
    chk({nm, " launch"}, 64'(status()), (code == MULT) ? 64'h18 : 64'h14);
    for (int c = 2; c <= int'(lat) + 1; c++) begin
      step();
      chk({nm, " busy"}, 64'(status()), 64'h10);
    end
    step();
    chk({nm, " done"}, 64'({status(), op_ready}), 64'h05);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    step();
    chk({nm, " after"}, 64'(status()), 64'h00);
  endtask

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a, b;
    logic [31:0] eh, el;
    logic        edone, eexc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{MTHI,   32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
    vecs[1] = '{MTLO,   32'h12345678, 32'h9, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0};
    vecs[2] = '{3'b100, 32'h0000FFFF, 32'h1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0};
    vecs[3] = '{DIV,    32'h5,        32'h0, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1};
    vecs[4] = '{3'b111, 32'h1,        32'h2, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0};
    vecs[5] = '{MTHI,   32'h11,       32'h0, 32'h11,       32'h12345678, 1'b1, 1'b0};
    vecs[6] = '{MTLO,   32'h22,       32'h0, 32'h11,       32'h22,       1'b1, 1'b0};
    vecs[7] = '{DIV,    32'h11,       32'h0, 32'h11,       32'h22,       1'b0, 1'b1};

    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0;
    step();
    step();
    chk("reset hi", 64'(hi), 64'h0);
    chk("reset lo", 64'(lo), 64'h0);
    chk("reset units", {unit_a, unit_b}, 64'h0);
    chk("reset status", 64'({status(), op_ready}), 64'h01);
    reset = 1'b0;
    step();

    // Back-to-back single-cycle ops, one accepted per cycle
    for (int i = 0; i < 8; i++) begin
      op_valid = 1'b1; op_code = vecs[i].code; op_a = vecs[i].a; op_b = vecs[i].b;
      step();
      chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].eh));
      chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].el));
      chk($sformatf("vec%0d status", i), 64'({status(), op_ready}),
          64'({1'b0, 2'b00, vecs[i].edone, vecs[i].eexc, 1'b1}));
      chk($sformatf("vec%0d units", i), {unit_a, unit_b}, {vecs[i].a, vecs[i].b});
    end
    op_valid = 1'b0;
    step();
    chk("idle after vecs", 64'(status()), 64'h00);

    // Backstop: div_zero raised mid-WAIT aborts the divide
    op_valid = 1'b1; op_code = DIV; op_a = 32'd9; op_b = 32'd3;
    step();
    op_valid = 1'b0;
    chk("bs launch", 64'(status()), 64'h14);
    repeat (4) step();
    force_dz = 1'b1;
    step();
    force_dz = 1'b0;
    chk("bs abort", 64'({status(), op_ready}), 64'h03);
    chk("bs hilo", {hi, lo}, {32'h11, 32'h22});
    step();
    chk("bs after", 64'(status()), 64'h00);
    repeat (40) step();
    chk("bs no late wb", {hi, lo, 32'(status())}, {32'h11, 32'h22, 32'h0});

    run_op("div7_2", DIV, 32'd7, 32'd2, DLAT, 32'd1, 32'd3);

    // MTHI followed immediately by a MULT
    op_valid = 1'b1; op_code = MTHI; op_a = 32'hDEADBEEF; op_b = 32'h0;
    step();
    chk("mthi hi", 64'(hi), 64'hDEADBEEF);
    chk("mthi done", 64'(status()), 64'h02);
    run_op("mult-5_3", MULT, 32'hFFFFFFFB, 32'd3, MLAT, 32'hFFFFFFFF, 32'hFFFFFFF1);

    // div_zero is ignored for MULT
    force_dz = 1'b1;
    run_op("mult_dz", MULT, 32'd4, 32'd5, MLAT, 32'd0, 32'd20);
    force_dz = 1'b0;

    // Reset in the middle of a divide
    op_valid = 1'b1; op_code = DIV; op_a = 32'd40; op_b = 32'd6;
    step();
    op_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst hilo", {hi, lo}, 64'h0);
    chk("rst status", 64'({status(), op_ready}), 64'h01);
    for (int c = 0; c < 40; c++) begin
      step();
      chk("rst quiet", 64'(status()), 64'h00);
    end
    run_op("div100_7", DIV, 32'd100, 32'd7, DLAT, 32'd2, 32'd14);

    // op_valid held high across a MULT: second accept only on the done cycle
    op_valid = 1'b1; op_code = MULT; op_a = 32'd6; op_b = 32'd7;
    step();
    chk("hold launch", 64'(status()), 64'h18);
    for (int c = 2; c <= int'(MLAT) + 1; c++) begin
      step();
      chk("hold busy", 64'(status()), 64'h10);
    end
    step();
    chk("hold done", 64'({status(), op_ready}), 64'h05);
    chk("hold hilo", {hi, lo}, {32'd0, 32'd42});
    op_a = 32'd2; op_b = 32'hFFFFFFFD;
    step();
    op_valid = 1'b0;
    chk("hold relaunch", 64'(status()), 64'h18);
    chk("hold units", {unit_a, unit_b}, {32'd2, 32'hFFFFFFFD});
    for (int c = 2; c <= int'(MLAT) + 1; c++) begin
      step();
      chk("hold2 busy", 64'(status()), 64'h10);
    end
    step();
    chk("hold2 done", 64'(status()), 64'h02);
    chk("hold2 hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFA});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Sequencer between the multicycle CPU control unit and the shared multiply and divide units. It accepts one HI/LO operation at a time and launches the matching unit with a one-cycle start pulse. It counts that unit's fixed latency, then writes the result into the architectural HI/LO registers. It also stalls the control unit while busy and raises a divide-by-zero exception pulse in place of a writeback.

## Interface
Parameters:
- MULT_LATENCY, 33, cycles from the mult_start cycle to the cycle mult_hi/mult_lo are valid (≥2)
- DIV_LATENCY, 34, cycles from the div_start cycle to the cycle div_hi/div_lo/div_zero are valid (≥2)
- CNT_W, 6, width of the latency counter; must hold max latency − 1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  request from control unit
- op_code  in  3  000 MULT, 001 DIV, 010 MTHI, 011 MTLO, others reserved
- op_a, op_b  in  32  operands: rs, rt; MTHI/MTLO use op_a
- op_ready  out  1  high in IDLE; a request is accepted when op_valid && op_ready
- unit_a, unit_b  out  32  operands registered at accept, held until the next accept
- mult_start, div_start  out  1  one-cycle launch pulses
- mult_hi, mult_lo  in  32  multiplier result
- div_hi, div_lo  in  32  divider remainder and quotient
- div_zero  in  1  divider zero-divisor flag
- hi, lo  out  32  architectural HI/LO, read directly for MFHI/MFLO
- busy  out  1  state ≠ IDLE; stalls the control unit
- done  out  1  one-cycle pulse: a new HI/LO value is visible this cycle
- div0_exc  out  1  one-cycle divide-by-zero exception pulse

## Operation
- Controller states are IDLE, LAUNCH, WAIT and WB. It holds a latched op and a CNT_W-bit counter.
- **IDLE, request accepted:**
  - MULT or DIV with op_b ≠ 0: latch op and operands, go to LAUNCH.
  - DIV with op_b = 0: no launch. div0_exc pulses next cycle, hi/lo are unchanged, done stays low. Stay in IDLE.
  - MTHI or MTLO: hi or lo ← op_a at the accept edge. done pulses next cycle. Stay in IDLE.
  - Reserved op_code: accepted and ignored. done pulses next cycle.
- **LAUNCH (1 cycle):** pulse mult_start or div_start for the latched op. Clear the counter. Go to WAIT.
- **WAIT:** the counter increments each cycle. Go to WB when counter = LAT − 1 − 1, where LAT is the latched op's latency; WAIT lasts LAT − 1 cycles.
- **WB (1 cycle):** sample the unit outputs and update hi/lo at the end of the cycle. Go to IDLE, with done high in that first IDLE cycle.
- **div_zero backstop:** if the latched op is DIV and div_zero is high in any WAIT or WB cycle, abort to IDLE. div0_exc pulses in the next cycle, with no HI/LO write and no done. div_zero is ignored for MULT.
- The controller applies no sign handling; operands pass raw and the units own signedness.
- op_valid asserted while busy is ignored and not queued.
- The done/IDLE cycle has op_ready = 1, so back-to-back accept is allowed.

## Timing
- Reset values: hi = lo = 0, unit_a = unit_b = 0, all pulse outputs 0, busy = 0, op_ready = 1, state IDLE, counter 0.
- MULT/DIV timeline, with accept at cycle A:
  - Start pulse at A+1.
  - busy high for cycles A+1 through A+LAT+1.
  - Unit outputs sampled at A+LAT+1.
  - New hi/lo and done at A+LAT+2.
- MTHI/MTLO: new value and done at A+1, busy never asserts.
- Zero divisor detected at accept: div0_exc at A+1.
- Backstop abort: div0_exc one cycle after div_zero is seen. state is IDLE in the same cycle as the pulse.
- Reset mid-operation: return to IDLE on that edge. hi/lo clear, no done, no div0_exc, and no start pulse in the cycle following reset.

## Test plan
- Reset → hi = lo = 0, busy = 0, op_ready = 1, no pulses.
- DIV 7, 2 with a stub divider (DIV_LATENCY = 34), accept at cycle 0 → div_start at cycle 1; busy for cycles 1–35; done at cycle 36 with hi = 1, lo = 3.
- hi/lo preset to 0x11/0x22, DIV op_b = 0 → no div_start; div0_exc at cycle 1; hi/lo stay 0x11/0x22. Repeat with stub div_zero forced high at cycle 5 → div0_exc at cycle 6, idle, hi/lo unchanged.
- MTHI 0xDEADBEEF → hi = 0xDEADBEEF and done at cycle 1. Then MULT −5, 3 accepted on the next cycle (MULT_LATENCY = 33) → done 35 cycles after accept with hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- Reset at cycle 10 of a DIV → no done; hi = lo = 0; op_ready = 1 the next cycle; a new DIV then completes normally.
- op_valid held high throughout a MULT → no second accept while busy; a second MULT is accepted on the done cycle, and its mult_start follows one cycle later.
